// File: rtl/fb_axi_pkg.sv
// fb_axi_pkg: shared widths, response codes and FSM states for the framebuffer AXI responder
package fb_axi_pkg;
    localparam int FB_DATA_W = 256;
    localparam int FB_ADDR_W = 29;
    localparam int FB_STRB_W = 32;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {IDLE, WRITE, WRESP, RD} state_t;
endpackage

// File: rtl/fb_axi_bram.sv
// fb_axi_bram: single-port byte-enable RAM with registered read; read_data holds while enable is low
module fb_axi_bram import fb_axi_pkg::*; #(
    parameter int MEM_WORDS = 4096,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic                 input_clock,
    input  logic                 enable,
    input  logic                 write_enable,
    input  logic [AW-1:0]        address,
    input  logic [FB_STRB_W-1:0] byte_enable,
    input  logic [FB_DATA_W-1:0] write_data,
    output logic [FB_DATA_W-1:0] read_data
);
    logic [FB_DATA_W-1:0] mem [MEM_WORDS];
    always_ff @(posedge input_clock)
        if (enable) begin
            read_data <= mem[address];
            for (int i = 0; i < FB_STRB_W; i++)
                if (write_enable && byte_enable[i]) mem[address][i*8 +: 8] <= write_data[i*8 +: 8];
        end
endmodule

// File: rtl/fb_axi_responder.sv
// fb_axi_responder: BRAM-backed AXI4 slave for the 256-bit framebuffer port
// FB_AXI_RESP_RANGE_CHECK_EN: reject bursts running past the last word with SLVERR instead of wrapping
module fb_axi_responder import fb_axi_pkg::*; #(
    parameter int MEM_WORDS = 4096,
    parameter int MAX_BURST = 256
) (
    input  logic                 axi_clock,
    input  logic                 axi_resetn,
    input  logic                 axi_awid,
    input  logic [FB_ADDR_W-1:0] axi_awaddr,
    input  logic [7:0]           axi_awlen,
    input  logic [2:0]           axi_awsize,
    input  logic [1:0]           axi_awburst,
    input  logic                 axi_awlock,
    input  logic [3:0]           axi_awcache,
    input  logic [2:0]           axi_awprot,
    input  logic [3:0]           axi_awqos,
    input  logic                 axi_awvalid,
    output logic                 axi_awready,
    input  logic [FB_DATA_W-1:0] axi_wdata,
    input  logic [FB_STRB_W-1:0] axi_wstrb,
    input  logic                 axi_wlast,
    input  logic                 axi_wvalid,
    output logic                 axi_wready,
    output logic                 axi_bid,
    output logic [1:0]           axi_bresp,
    output logic                 axi_bvalid,
    input  logic                 axi_bready,
    input  logic                 axi_arid,
    input  logic [FB_ADDR_W-1:0] axi_araddr,
    input  logic [7:0]           axi_arlen,
    input  logic [2:0]           axi_arsize,
    input  logic [1:0]           axi_arburst,
    input  logic                 axi_arlock,
    input  logic [3:0]           axi_arcache,
    input  logic [2:0]           axi_arprot,
    input  logic [3:0]           axi_arqos,
    input  logic                 axi_arvalid,
    output logic                 axi_arready,
    output logic                 axi_rid,
    output logic [FB_DATA_W-1:0] axi_rdata,
    output logic [1:0]           axi_rresp,
    output logic                 axi_rlast,
    output logic                 axi_rvalid,
    input  logic                 axi_rready,
    output logic                 proto_err
);
    localparam int AW = $clog2(MEM_WORDS);
    state_t state, state_nx;
    logic last_rd, id, oor, pend, pend_last, g_oor;
    logic w_hs, w_end, r_free, issue, load, r_done;
    logic [AW-1:0] word;
    logic [7:0] len, cnt, g_len;
    logic [8:0] rissue;
    logic [FB_ADDR_W-1:0] g_addr;
    logic [FB_DATA_W-1:0] mem_rdata;
    logic unused_ok;
    assign axi_awready = axi_resetn && state == IDLE && axi_awvalid && (!axi_arvalid || last_rd);
    assign axi_arready = axi_resetn && state == IDLE && axi_arvalid && (!axi_awvalid || !last_rd);
    assign axi_wready = state == WRITE;
    assign axi_bvalid = state == WRESP;
    assign axi_bid = id;
    assign axi_rid = id;
    assign axi_bresp = oor ? RESP_SLVERR : RESP_OKAY;
    assign axi_rresp = oor ? RESP_SLVERR : RESP_OKAY;
    assign g_addr = axi_awready ? axi_awaddr : axi_araddr;
    assign g_len = axi_awready ? axi_awlen : axi_arlen;
`ifdef FB_AXI_RESP_RANGE_CHECK_EN
    assign g_oor = {1'b0, g_addr[FB_ADDR_W-1:5]} + 25'(g_len) >= 25'(MEM_WORDS);
`else
    assign g_oor = 1'b0;
`endif
    assign w_hs = axi_wready && axi_wvalid;
    assign w_end = w_hs && cnt == len;
    // A read is issued only when the output register frees up; the BRAM holds the beat meanwhile
    assign r_free = !axi_rvalid || axi_rready;
    assign issue = state == RD && r_free && rissue <= {1'b0, len};
    assign load = pend && r_free;
    assign r_done = axi_rvalid && axi_rready && axi_rlast;
    assign unused_ok = &{1'b0, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_awqos,
                         axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arqos, g_addr};
    always_comb begin
        state_nx = state;
        state_nx = axi_awready ? WRITE :
                   axi_arready ? RD :
                   w_end ? WRESP :
                   (state == WRESP && axi_bready) || r_done ? IDLE : state;
    end
    always_ff @(posedge axi_clock)
        if (!axi_resetn) begin
            state <= IDLE;
            last_rd <= 1'b1;
            id <= 1'b0;
            oor <= 1'b0;
            word <= '0;
            len <= '0;
            cnt <= '0;
            rissue <= '0;
            pend <= 1'b0;
            pend_last <= 1'b0;
            axi_rvalid <= 1'b0;
            axi_rlast <= 1'b0;
            axi_rdata <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (axi_awready || axi_arready) begin
                last_rd <= axi_arready;
                id <= axi_awready ? axi_awid : axi_arid;
                oor <= g_oor;
                word <= g_addr[5 +: AW];
                len <= g_len;
                cnt <= '0;
                rissue <= '0;
            end
            if (w_hs) begin
                word <= word + 1'b1;
                cnt <= cnt + 1'b1;
            end
            if (issue) begin
                word <= word + 1'b1;
                rissue <= rissue + 1'b1;
                pend_last <= rissue[7:0] == len;
            end
            pend <= issue || (pend && !load);
            if (load) begin
                axi_rvalid <= 1'b1;
                axi_rlast <= pend_last;
                axi_rdata <= oor ? '0 : mem_rdata;
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 1'b0;
                axi_rlast <= 1'b0;
            end
            if ((w_hs && axi_wlast != (cnt == len)) || (state == IDLE && axi_wvalid) ||
                ((axi_awready || axi_arready) && int'(g_len) + 1 > MAX_BURST))
                proto_err <= 1'b1;
        end
    fb_axi_bram #(.MEM_WORDS(MEM_WORDS)) u_bram (
        .input_clock (axi_clock),
        .enable      (w_hs || issue),
        .write_enable(w_hs && !oor),
        .address     (word),
        .byte_enable (axi_wstrb),
        .write_data  (axi_wdata),
        .read_data   (mem_rdata)
    );
endmodule

// File: tb/tb_fb_axi_responder.sv
// tb_fb_axi_responder: scoreboard bench for fb_axi_responder in its default (wrapping, always-OKAY) build
module tb_fb_axi_responder;
    import fb_axi_pkg::*;
    localparam int MW = 4096;
    typedef struct {logic [255:0] d; logic l; logic id;} rexp_t;
    logic axi_clock = 0, axi_resetn;
    logic axi_awid, axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic [28:0] axi_awaddr, axi_araddr;
    logic [7:0] axi_awlen, axi_arlen;
    logic [255:0] axi_wdata, axi_rdata;
    logic [31:0] axi_wstrb;
    logic axi_bid, axi_bvalid, axi_bready, axi_arid, axi_arvalid, axi_arready;
    logic [1:0] axi_bresp, axi_rresp;
    logic axi_rid, axi_rlast, axi_rvalid, axi_rready, proto_err;
    logic [255:0] model [MW];
    rexp_t rq[$];
    logic [2:0] bq[$];
    rexp_t e;
    logic [2:0] be;
    logic stall = 0;
    logic [255:0] hold;
    int total = 0, bad = 0;
    always #5 axi_clock = ~axi_clock;
    fb_axi_responder dut (
        .axi_clock(axi_clock), .axi_resetn(axi_resetn),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(3'd5),
        .axi_awburst(2'b01), .axi_awlock(1'b0), .axi_awcache(4'd0), .axi_awprot(3'd0), .axi_awqos(4'd0),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(3'd5),
        .axi_arburst(2'b01), .axi_arlock(1'b0), .axi_arcache(4'd0), .axi_arprot(3'd0), .axi_arqos(4'd0),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .proto_err(proto_err)
    );
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge axi_clock);
        #1;
    endtask
    // Handshakes complete at the posedge, so popping at the preceding negedge pairs each beat with its expectation
    always @(negedge axi_clock) begin
        if (stall && axi_rvalid) chk("r_stable", axi_rdata, hold);
        stall = axi_rvalid && !axi_rready;
        hold = axi_rdata;
        if (axi_rvalid && axi_rready) begin
            chk("r_avail", rq.size() != 0, 1);
            if (rq.size() != 0) begin
                e = rq.pop_front();
                chk("rdata", axi_rdata, e.d);
                chk("rlast", axi_rlast, e.l);
                chk("rid", axi_rid, e.id);
                chk("rresp", axi_rresp, RESP_OKAY);
            end
        end
        if (axi_bvalid && axi_bready) begin
            chk("b_avail", bq.size() != 0, 1);
            if (bq.size() != 0) begin
                be = bq.pop_front();
                chk("bid", axi_bid, be[2]);
                chk("bresp", axi_bresp, be[1:0]);
            end
        end
    end
    task automatic aw_req(input logic id, input int w0, input int len);
        axi_awid = id;
        axi_awaddr = {24'(w0), 5'b0};
        axi_awlen = 8'(len);
        axi_awvalid = 1;
        for (int j = 0; j < 20; j++) begin
            #1;
            if (axi_awready) break;
            tick();
        end
        chk("aw_grant", axi_awready, 1);
        tick();
        axi_awvalid = 0;
    endtask
    task automatic w_send(input int w0, input int len, input int base, input logic [255:0] fill,
                          input logic [31:0] strb, input int early);
        for (int i = 0; i <= len; i++) begin
            axi_wdata = fill | {8{32'(base + i)}};
            axi_wstrb = strb;
            axi_wlast = early >= 0 ? i == early : i == len;
            axi_wvalid = 1;
            for (int b = 0; b < 32; b++)
                if (strb[b]) model[(w0 + i) % MW][b*8 +: 8] = axi_wdata[b*8 +: 8];
            for (int j = 0; j < 20; j++) begin
                #1;
                if (axi_wready) break;
                tick();
            end
            chk("w_ready", axi_wready, 1);
            if (i == len) chk("b_early", axi_bvalid, 0);
            tick();
        end
        axi_wvalid = 0;
        axi_wlast = 0;
        chk("b_lat", axi_bvalid, 1);
    endtask
    task automatic b_wait();
        for (int j = 0; j < 10; j++) begin
            if (bq.size() == 0) break;
            tick();
        end
        chk("b_drain", bq.size(), 0);
    endtask
    task automatic write(input logic id, input int w0, input int len, input int base,
                         input logic [255:0] fill, input logic [31:0] strb, input int early);
        bq.push_back({id, RESP_OKAY});
        aw_req(id, w0, len);
        w_send(w0, len, base, fill, strb, early);
        b_wait();
    endtask
    task automatic push_r(input logic id, input int w0, input int len);
        for (int i = 0; i <= len; i++) rq.push_back('{model[(w0 + i) % MW], i == len, id});
    endtask
    task automatic ar_req(input logic id, input int w0, input int len);
        push_r(id, w0, len);
        axi_rready = 1;
        axi_arid = id;
        axi_araddr = {24'(w0), 5'b0};
        axi_arlen = 8'(len);
        axi_arvalid = 1;
        for (int j = 0; j < 20; j++) begin
            #1;
            if (axi_arready) break;
            tick();
        end
        chk("ar_grant", axi_arready, 1);
        tick();
        axi_arvalid = 0;
    endtask
    task automatic r_drain(input bit pat);
        for (int k = 0; k < 400; k++) begin
            if (rq.size() == 0) break;
            axi_rready = pat ? k % 3 == 0 : 1'b1;
            tick();
        end
        chk("r_drain", rq.size(), 0);
        axi_rready = 1;
    endtask
    task automatic read(input logic id, input int w0, input int len, input bit pat);
        ar_req(id, w0, len);
        chk("rv_e0", axi_rvalid, 0);
        tick();
        chk("rv_e1", axi_rvalid, 0);
        tick();
        chk("rv_e2", axi_rvalid, 1);
        r_drain(pat);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
    initial begin
        axi_resetn = 0;
        {axi_awid, axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid} = '0;
        {axi_arid, axi_araddr, axi_arlen, axi_arvalid} = '0;
        axi_bready = 1;
        axi_rready = 1;
        axi_awvalid = 1;
        repeat (3) tick();
        chk("rst_awready", axi_awready, 0);
        axi_awvalid = 0;
        chk("rst_wready", axi_wready, 0);
        chk("rst_bvalid", axi_bvalid, 0);
        chk("rst_rvalid", axi_rvalid, 0);
        chk("rst_rlast", axi_rlast, 0);
        chk("rst_rdata", axi_rdata, 0);
        chk("rst_perr", proto_err, 0);
        axi_resetn = 1;
        tick();
        // simultaneous AW/AR: write wins first tie, read follows the B handshake
        axi_awid = 0; axi_awaddr = {24'd200, 5'b0}; axi_awlen = 0; axi_awvalid = 1;
        axi_arid = 1; axi_araddr = {24'd200, 5'b0}; axi_arlen = 0; axi_arvalid = 1;
        #1;
        chk("tie1_aw", axi_awready, 1);
        chk("tie1_ar", axi_arready, 0);
        bq.push_back({1'b0, RESP_OKAY});
        tick();
        axi_awvalid = 0;
        chk("tie1_ar_hold", axi_arready, 0);
        w_send(200, 0, 77, '0, '1, -1);
        push_r(1, 200, 0);
        tick();
        chk("ar_after_b", axi_arready, 1);
        tick();
        axi_arvalid = 0;
        r_drain(0);
        axi_awid = 1; axi_awaddr = {24'd201, 5'b0}; axi_awlen = 0; axi_awvalid = 1;
        axi_arid = 0; axi_araddr = {24'd200, 5'b0}; axi_arlen = 0; axi_arvalid = 1;
        #1;
        chk("tie2_aw", axi_awready, 1);
        chk("tie2_ar", axi_arready, 0);
        bq.push_back({1'b1, RESP_OKAY});
        tick();
        axi_awvalid = 0;
        w_send(201, 0, 99, '0, '1, -1);
        push_r(0, 200, 0);
        b_wait();
        tick();
        axi_arvalid = 0;
        r_drain(0);
        // round trip, then backpressured re-read
        write(0, 8, 15, 0, '0, '1, -1);
        read(1, 8, 15, 0);
        read(0, 8, 15, 1);
        // byte strobes
        write(0, 100, 0, 0, '1, '1, -1);
        write(1, 100, 0, 0, '0, 32'h0000000F, -1);
        read(1, 100, 0, 0);
        // wrap past the last word
        write(1, MW - 2, 3, 40, '0, '1, -1);
        read(0, 0, 1, 0);
        read(1, MW - 2, 1, 0);
        chk("perr_clean", proto_err, 0);
        write(0, 300, 15, 7, '0, '1, 5);
        chk("perr_wlast", proto_err, 1);
        read(0, 300, 15, 0);
        // reset during beat 7 of a read
        ar_req(1, 8, 15);
        for (int j = 0; j < 100; j++) begin
            if (rq.size() <= 9) break;
            tick();
        end
        chk("rst_mid_at7", rq.size(), 9);
        axi_rready = 0;
        axi_resetn = 0;
        tick();
        chk("rst_mid_rvalid", axi_rvalid, 0);
        chk("rst_mid_rid", axi_rid, 0);
        chk("rst_mid_perr", proto_err, 0);
        rq.delete();
        axi_resetn = 1;
        read(0, 8, 3, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
